keypad_time_loader: RTL and testbench

//  Front end of the microwave timer: turns keypad presses into the serial digit-load stream the

---
 rtl/keypad_time_loader.sv | 192 +++++++++++++++++++
 tb/tb_keypad_time_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_loader.sv
// Keypad front end for the microwave timer: debounces key presses and turns them into
// the serial digit-load stream, start and cancel pulses consumed by the countdown chain.
module keypad_time_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 3
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       timer_running,
    output logic [3:0] data,
    output logic       loadn,
    output logic       start,
    output logic       cancel,
    output logic [1:0] digits_entered,
    output logic       entry_active
);

    localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CLW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    localparam logic [3:0] KEY_START = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_DEBOUNCE     = 3'd1,
        S_ACT          = 3'd2,
        S_WAIT_RELEASE = 3'd3,
        S_CLEARING     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     key_q, key_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CLW-1:0] clr_q, clr_d;

    logic [3:0] data_q, data_d;
    logic       loadn_q, loadn_d;
    logic       start_q, start_d;
    logic       cancel_q, cancel_d;
    logic [1:0] digits_q, digits_d;
    logic       active_q, active_d;

    logic key_is_digit;
    logic entry_open;
    logic clear_last;

    assign key_is_digit = (key_q <= 4'd9);
    assign entry_open   = (digits_q < 2'(MAX_DIGITS));
    assign clear_last   = (clr_q == CLW'(MAX_DIGITS - 1));

    // State register, latched key and sequencing counters.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            key_q   <= 4'd0;
            cnt_q   <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    state_d = S_DEBOUNCE;
                    key_d   = key_code;
                    cnt_d   = CW'(1);
                end
            end
            S_DEBOUNCE: begin
                // Any drop or code change abandons the candidate; a new code is re-latched via IDLE.
                if (!key_valid || (key_code != key_q)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d = S_ACT;
                    end
                end
            end
            S_ACT: begin
                cnt_d = '0;
                clr_d = '0;
                if ((key_q == KEY_CLEAR) && !timer_running) begin
                    state_d = S_CLEARING;
                end else begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            S_CLEARING: begin
                // Runs to completion even if timer_running rises meanwhile.
                if (clear_last) begin
                    state_d = S_WAIT_RELEASE;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + CLW'(1);
                end
            end
            S_WAIT_RELEASE: begin
                if (!key_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        data_d   = data_q;
        loadn_d  = 1'b0;
        start_d  = 1'b0;
        cancel_d = 1'b0;
        digits_d = digits_q;
        active_d = active_q;
        case (state_q)
            S_ACT: begin
                if (key_is_digit) begin
                    if (!timer_running && entry_open) begin
                        data_d   = key_q;
                        loadn_d  = 1'b1;
                        digits_d = digits_q + 2'd1;
                        active_d = 1'b1;
                    end
                end else if (key_q == KEY_START) begin
                    if (!timer_running && (digits_q != 2'd0)) begin
                        start_d  = 1'b1;
                        digits_d = 2'd0;
                        active_d = 1'b0;
                    end
                end else if (key_q == KEY_CLEAR) begin
                    if (timer_running) begin
                        cancel_d = 1'b1;
                    end
                end
            end
            S_CLEARING: begin
                // Shift zeros through every stage of the chain.
                data_d  = 4'd0;
                loadn_d = 1'b1;
                if (clear_last) begin
                    digits_d = 2'd0;
                    active_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            data_q   <= 4'd0;
            loadn_q  <= 1'b0;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            digits_q <= 2'd0;
            active_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            loadn_q  <= loadn_d;
            start_q  <= start_d;
            cancel_q <= cancel_d;
            digits_q <= digits_d;
            active_q <= active_d;
        end
    end

    assign data           = data_q;
    assign loadn          = loadn_q;
    assign start          = start_q;
    assign cancel         = cancel_q;
    assign digits_entered = digits_q;
    assign entry_active   = active_q;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Bench for keypad_time_loader: scripted key presses, an expected-digit queue checked on
// every load strobe, and a three-stage model of the minutes/seconds chain.
module tb_keypad_time_loader;

    logic       clock;
    logic       clrn;
    logic [3:0] key_code;
    logic       key_valid;
    logic       timer_running;
    logic [3:0] data;
    logic       loadn;
    logic       start;
    logic       cancel;
    logic [1:0] digits_entered;
    logic       entry_active;

    keypad_time_loader dut (
        .clock          (clock),
        .clrn           (clrn),
        .key_code       (key_code),
        .key_valid      (key_valid),
        .timer_running  (timer_running),
        .data           (data),
        .loadn          (loadn),
        .start          (start),
        .cancel         (cancel),
        .digits_entered (digits_entered),
        .entry_active   (entry_active)
    );

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard and counter-chain model.
    logic [3:0] exp_q[$];
    logic [3:0] ch_mins = 4'd0;
    logic [3:0] ch_tens = 4'd0;
    logic [3:0] ch_ones = 4'd0;
    int load_count = 0;
    int start_count = 0;
    int cancel_count = 0;
    int last_load_cyc = 0;
    int run_len = 0;
    int max_run = 0;

    always @(negedge clock) begin
        if (clrn) begin
            if (loadn) begin
                run_len++;
                load_count++;
                last_load_cyc = cyc;
                ch_mins = ch_tens;
                ch_tens = ch_ones;
                ch_ones = data;
                if (exp_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
                else chk("load_data", 32'(data), 32'(exp_q.pop_front()));
            end else begin
                run_len = 0;
            end
            if (run_len > max_run) max_run = run_len;
            if (start) start_count++;
            if (cancel) cancel_count++;
            if ((int'(loadn) + int'(start) + int'(cancel)) > 1)
                chk("strobe_exclusive", 32'(int'(loadn) + int'(start) + int'(cancel)), 32'd1);
        end
    end

    // Driver.
    int press_cyc = 0;

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        press_cyc = cyc;
        key_code  = code;
        key_valid = 1'b1;
        repeat (hold) @(posedge clock);
        #1 key_valid = 1'b0;
        repeat (rel) @(posedge clock);
        #1;
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    endtask

    initial begin
        #2_000_000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: simulation did not complete in time");
        summary();
        $finish;
    end

    int n0, s0, c0;
    logic [3:0] digs[3];

    initial begin
        clrn          = 1'b0;
        key_code      = 4'd0;
        key_valid     = 1'b0;
        timer_running = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_loadn", 32'(loadn), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_cancel", 32'(cancel), 32'd0);
        chk("rst_digits", 32'(digits_entered), 32'd0);
        chk("rst_active", 32'(entry_active), 32'd0);
        clrn = 1'b1;
        @(posedge clock);
        #1;

        // Enter 1,2,3: each loads 5 cycles after the press.
        digs[0] = 4'd1; digs[1] = 4'd2; digs[2] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(digs[i]);
            n0 = load_count;
            press(digs[i], 6, 3);
            chk("t1_load_count", 32'(load_count - n0), 32'd1);
            chk("t1_latency", 32'(last_load_cyc - press_cyc), 32'd5);
        end
        chk("t1_digits", 32'(digits_entered), 32'd3);
        chk("t1_active", 32'(entry_active), 32'd1);
        chk("t1_mins", 32'(ch_mins), 32'd1);
        chk("t1_tens", 32'(ch_tens), 32'd2);
        chk("t1_ones", 32'(ch_ones), 32'd3);

        // Fourth digit is dropped, then START.
        n0 = load_count;
        press(4'd9, 6, 3);
        chk("t2_overflow_load", 32'(load_count - n0), 32'd0);
        chk("t2_digits_sat", 32'(digits_entered), 32'd3);
        s0 = start_count;
        press(4'hA, 6, 3);
        chk("t2_start_cycles", 32'(start_count - s0), 32'd1);
        chk("t2_digits", 32'(digits_entered), 32'd0);
        chk("t2_active", 32'(entry_active), 32'd0);
        s0 = start_count;
        press(4'hA, 6, 3);
        chk("t2_start_empty", 32'(start_count - s0), 32'd0);

        // Short glitch, then a code change mid-debounce.
        n0 = load_count;
        press(4'd2, 3, 3);
        chk("t3_glitch_load", 32'(load_count - n0), 32'd0);
        exp_q.push_back(4'd5);
        n0 = load_count;
        key_code  = 4'd2;
        key_valid = 1'b1;
        repeat (2) @(posedge clock);
        #1 key_code = 4'd5;
        repeat (8) @(posedge clock);
        #1 key_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t3_change_load", 32'(load_count - n0), 32'd1);
        chk("t3_digits", 32'(digits_entered), 32'd1);
        n0 = load_count;
        press(4'hC, 6, 3);
        chk("t3_ignored_key", 32'(load_count - n0), 32'd0);

        // CLEAR with two digits zero-fills the chain.
        exp_q.push_back(4'd6);
        press(4'd6, 6, 3);
        chk("t4_digits_before", 32'(digits_entered), 32'd2);
        for (int i = 0; i < 3; i++) exp_q.push_back(4'd0);
        n0 = load_count;
        c0 = cancel_count;
        max_run = 0;
        press(4'hB, 6, 6);
        chk("t4_clear_loads", 32'(load_count - n0), 32'd3);
        chk("t4_clear_run", 32'(max_run), 32'd3);
        chk("t4_no_cancel", 32'(cancel_count - c0), 32'd0);
        chk("t4_digits", 32'(digits_entered), 32'd0);
        chk("t4_active", 32'(entry_active), 32'd0);
        chk("t4_chain", 32'({ch_mins, ch_tens, ch_ones}), 32'd0);

        // Entry locked while the timer runs; CLEAR cancels.
        exp_q.push_back(4'd8);
        press(4'd8, 6, 3);
        timer_running = 1'b1;
        n0 = load_count;
        s0 = start_count;
        c0 = cancel_count;
        press(4'd7, 6, 3);
        press(4'hA, 6, 3);
        chk("t5_locked_load", 32'(load_count - n0), 32'd0);
        chk("t5_locked_start", 32'(start_count - s0), 32'd0);
        chk("t5_digits", 32'(digits_entered), 32'd1);
        press(4'hB, 6, 3);
        chk("t5_cancel_cycles", 32'(cancel_count - c0), 32'd1);
        chk("t5_cancel_noload", 32'(load_count - n0), 32'd0);
        timer_running = 1'b0;

        // Long hold acts once; reset during CLEARING aborts it.
        exp_q.push_back(4'd4);
        n0 = load_count;
        press(4'd4, 50, 3);
        chk("t6_hold_loads", 32'(load_count - n0), 32'd1);
        chk("t6_digits", 32'(digits_entered), 32'd2);
        key_code  = 4'hB;
        key_valid = 1'b1;
        repeat (6) @(posedge clock);
        #1 clrn = 1'b0;
        #1;
        chk("t6_rst_loadn", 32'(loadn), 32'd0);
        chk("t6_rst_data", 32'(data), 32'd0);
        chk("t6_rst_start", 32'(start), 32'd0);
        chk("t6_rst_cancel", 32'(cancel), 32'd0);
        chk("t6_rst_digits", 32'(digits_entered), 32'd0);
        chk("t6_rst_active", 32'(entry_active), 32'd0);
        key_valid = 1'b0;
        @(posedge clock);
        #1;
        n0 = load_count;
        clrn = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("t6_post_rst_load", 32'(load_count - n0), 32'd0);
        chk("t6_post_rst_digits", 32'(digits_entered), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
